lan_bus_sequencer: RTL

- Avalon-MM slave that runs timed read/write cycles on the external LAN controller's 16-bit parallel bus.
- Drives chip-select, CMD (index/data select), IOR#/IOW# and the bidirectional data-bus enables.
- Sits between the Nios system interconnect and the LAN chip pins.
- Replaces software bit-banging of the LAN chip-select PIO with hardware-sequenced setup/strobe/hold timing and waitrequest back-pressure.

---
 rtl/lan_bus_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lan_bus_sequencer.sv
// Avalon-MM slave that sequences setup/strobe/hold cycles on the LAN chip bus.
// Optional macro LAN_BUS_TIMING_REG_EN adds a run-time timing register at address 2.
module lan_bus_sequencer #(
    parameter int DATA_W     = 16,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              waitrequest,
    output logic              lan_cs_n,
    output logic              lan_cmd,
    output logic              lan_ior_n,
    output logic              lan_iow_n,
    output logic [DATA_W-1:0] lan_data_out,
    output logic              lan_data_oe,
    input  logic [DATA_W-1:0] lan_data_in
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] setup_v, strobe_v, hold_v;
    logic [DATA_W-1:0] rd_q, loc_rd;
    logic req, is_local, start;
    logic wr_q, wr_d, busy_d;

    assign req      = chipselect & (~read_n | ~write_n);
    assign is_local = address[1];
    assign start    = (state == IDLE) & req & ~is_local;

    // Local accesses never stall; external ones stall until DONE.
    assign waitrequest = req & ~is_local & (state != DONE);
    assign readdata    = (chipselect & is_local) ? loc_rd : rd_q;

`ifdef LAN_BUS_TIMING_REG_EN
    logic [11:0] tim_q;

    function automatic logic [3:0] fix0(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tim_q <= {4'(HOLD_CYC), 4'(STROBE_CYC), 4'(SETUP_CYC)};
        else if (chipselect && !write_n && address == 2'd2)
            tim_q <= {fix0(writedata[11:8]),
                      fix0(writedata[7:4]),
                      fix0(writedata[3:0])};
    end

    assign setup_v  = CNT_W'(tim_q[3:0]) - CNT_W'(1);
    assign strobe_v = CNT_W'(tim_q[7:4]) - CNT_W'(1);
    assign hold_v   = CNT_W'(tim_q[11:8]) - CNT_W'(1);
    assign loc_rd   = address[0] ? '0 : DATA_W'(tim_q);
`else
    assign setup_v  = CNT_W'(SETUP_CYC - 1);
    assign strobe_v = CNT_W'(STROBE_CYC - 1);
    assign hold_v   = CNT_W'(HOLD_CYC - 1);
    assign loc_rd   = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    cnt_d   = setup_v;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_d = STROBE;
                    cnt_d   = strobe_v;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt == '0) begin
                    state_d = HOLD;
                    cnt_d   = hold_v;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == '0)
                    state_d = DONE;
                else
                    cnt_d = cnt - CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wr_d   = start ? ~write_n : wr_q;
    assign busy_d = (state_d == SETUP) || (state_d == STROBE) ||
                    (state_d == HOLD);

    // Pin outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q         <= 1'b0;
            lan_cs_n     <= 1'b1;
            lan_ior_n    <= 1'b1;
            lan_iow_n    <= 1'b1;
            lan_cmd      <= 1'b0;
            lan_data_oe  <= 1'b0;
            lan_data_out <= '0;
            rd_q         <= '0;
        end else begin
            wr_q        <= wr_d;
            lan_cs_n    <= ~busy_d;
            lan_ior_n   <= ~((state_d == STROBE) && !wr_d);
            lan_iow_n   <= ~((state_d == STROBE) && wr_d);
            lan_data_oe <= busy_d && wr_d;
            if (start) begin
                lan_cmd <= address[0];
                if (!write_n)
                    lan_data_out <= writedata;
            end
            if (state == STROBE && cnt == '0 && !wr_q)
                rd_q <= lan_data_in;
        end
    end

endmodule
